// File: rtl/red_pitaya_ams_mon.sv
// red_pitaya_ams_mon: per-channel converter statistics (last/avg/min/max),
// threshold alarms and a PWM DAC setpoint bank on the system bus.
module red_pitaya_ams_mon #(
  parameter int N_CH    = 32,
  parameter int DW      = 12,
  parameter int AVG_LOG = 4,
  parameter int N_DAC   = 4,
  parameter int DAC_W   = 24
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   smp_valid_i,
  input  logic [4:0]             smp_ch_i,
  input  logic [15:0]            smp_data_i,
  output logic [N_DAC*DAC_W-1:0] dac_o,
  output logic [N_CH-1:0]        alarm_o,
  input  logic [31:0]            sys_addr,
  input  logic [31:0]            sys_wdata,
  input  logic [3:0]             sys_sel,
  input  logic                   sys_wen,
  input  logic                   sys_ren,
  output logic [31:0]            sys_rdata,
  output logic                   sys_err,
  output logic                   sys_ack
);

  localparam int AW = DW + AVG_LOG;
  localparam int CW = (AVG_LOG > 0) ? AVG_LOG : 1;
  localparam logic [CW-1:0] CNT_END = CW'((1 << AVG_LOG) - 1);

  logic [DW-1:0] last_q [N_CH];
  logic [DW-1:0] avg_q  [N_CH];
  logic [DW-1:0] min_q  [N_CH];
  logic [DW-1:0] max_q  [N_CH];
  logic [DW-1:0] hi_q   [N_CH];
  logic [DW-1:0] lo_q   [N_CH];
  logic [AW-1:0] acc_q  [N_CH];
  logic [CW-1:0] cnt_q  [N_CH];

  logic [N_DAC-1:0][DAC_W-1:0] dac_q;
  logic [N_CH-1:0]             alarm_q;
  logic                        frz_q;

  logic [19:0] a;
  logic [11:0] pg;
  logic [5:0]  idx;
  logic        aligned;
  logic        wr_ctrl;
  logic        wr_alarm;
  logic        clr;

  assign a        = sys_addr[19:0];
  assign pg       = a[19:8];
  assign idx      = a[7:2];
  assign aligned  = (a[1:0] == 2'b00);
  assign wr_ctrl  = sys_wen && (a == 20'h00400);
  assign wr_alarm = sys_wen && (a == 20'h00404);
  assign clr      = wr_ctrl && sys_wdata[0];

  logic [DW-1:0] s;
  logic          go;

  assign s  = smp_data_i[15 -: DW];
  assign go = smp_valid_i && !frz_q
           && ({1'b0, smp_ch_i} < 6'(N_CH));

  logic [AW-1:0] acc_sel;
  logic [CW-1:0] cnt_sel;
  logic [DW-1:0] hi_sel;
  logic [DW-1:0] lo_sel;

  // pick the addressed channel's accumulator and thresholds
  always_comb begin
    acc_sel = '0;
    cnt_sel = '0;
    hi_sel  = '0;
    lo_sel  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (smp_ch_i == 5'(i)) begin
        acc_sel = acc_q[i];
        cnt_sel = cnt_q[i];
        hi_sel  = hi_q[i];
        lo_sel  = lo_q[i];
      end
    end
  end

  logic [AW-1:0] sum;
  logic [DW-1:0] navg;
  logic          full;
  logic          viol;

  assign sum  = acc_sel + AW'(s);
  assign navg = DW'(sum >> AVG_LOG);
  assign full = (cnt_sel == CNT_END);
  assign viol = (navg > hi_sel) || (navg < lo_sel);

  // per-channel last/min/max/boxcar state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_CH; i++) begin
        last_q[i] <= '0;
        avg_q[i]  <= '0;
        min_q[i]  <= '1;
        max_q[i]  <= '0;
        acc_q[i]  <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (clr) begin
          min_q[i] <= '1;
          max_q[i] <= '0;
        end
        if (go && (smp_ch_i == 5'(i))) begin
          last_q[i] <= s;
          if (clr || (s < min_q[i])) min_q[i] <= s;
          if (clr || (s > max_q[i])) max_q[i] <= s;
          if (full) begin
            avg_q[i] <= navg;
            acc_q[i] <= '0;
            cnt_q[i] <= '0;
          end else begin
            acc_q[i] <= sum;
            cnt_q[i] <= cnt_q[i] + CW'(1);
          end
        end
      end
    end
  end

  logic [N_CH-1:0] aset;
  logic [N_CH-1:0] aclr;

  // alarm raised by a completed average that leaves [lo, hi]
  always_comb begin
    aset = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (go && full && viol && (smp_ch_i == 5'(i)))
        aset[i] = 1'b1;
    end
  end

  assign aclr = wr_alarm ? sys_wdata[N_CH-1:0] : '0;

  // sticky alarms; a new set beats a same-cycle clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) alarm_q <= '0;
    else       alarm_q <= (alarm_q & ~aclr) | aset;
  end

  // writable control, DAC and threshold registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frz_q <= 1'b0;
      dac_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        hi_q[i] <= '1;
        lo_q[i] <= '0;
      end
    end else if (sys_wen) begin
      if (wr_ctrl) frz_q <= sys_wdata[1];
      for (int k = 0; k < N_DAC; k++) begin
        if (aligned && (pg == 12'h003) && (idx == 6'(k)))
          dac_q[k] <= sys_wdata[DAC_W-1:0];
      end
      for (int i = 0; i < N_CH; i++) begin
        if (aligned && (pg == 12'h005) && (idx == 6'(i))) begin
          hi_q[i] <= sys_wdata[16 +: DW];
          lo_q[i] <= sys_wdata[0 +: DW];
        end
      end
    end
  end

  logic [31:0] rd;

  // read data mux; unmapped or out-of-range words read as zero
  always_comb begin
    rd = '0;
    if (aligned) begin
      unique case (1'b1)
        pg == 12'h000: begin
          for (int i = 0; i < N_CH; i++)
            if (idx == 6'(i)) rd[DW-1:0] = last_q[i];
        end
        pg == 12'h001: begin
          for (int i = 0; i < N_CH; i++)
            if (idx == 6'(i)) rd[DW-1:0] = avg_q[i];
        end
        pg == 12'h002: begin
          for (int i = 0; i < N_CH; i++) begin
            if (idx == 6'(i)) begin
              rd[16 +: DW] = max_q[i];
              rd[0 +: DW]  = min_q[i];
            end
          end
        end
        pg == 12'h003: begin
          for (int k = 0; k < N_DAC; k++)
            if (idx == 6'(k)) rd[DAC_W-1:0] = dac_q[k];
        end
        pg == 12'h004: begin
          if (idx == 6'd0)      rd[1]      = frz_q;
          else if (idx == 6'd1) rd[N_CH-1:0] = alarm_q;
        end
        pg == 12'h005: begin
          for (int i = 0; i < N_CH; i++) begin
            if (idx == 6'(i)) begin
              rd[16 +: DW] = hi_q[i];
              rd[0 +: DW]  = lo_q[i];
            end
          end
        end
        default: rd = '0;
      endcase
    end
  end

  // single-cycle bus response
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack   <= sys_wen | sys_ren;
      sys_rdata <= (sys_wen | sys_ren) ? rd : '0;
    end
  end

  assign sys_err = 1'b0;
  assign dac_o   = dac_q;
  assign alarm_o = alarm_q;

  logic unused_ok;
  assign unused_ok = ^{sys_sel, sys_addr, sys_wdata, smp_data_i};

endmodule

// File: tb/tb_red_pitaya_ams_mon.sv
// tb_red_pitaya_ams_mon: scoreboard bench with a window-based
// reference model, directed scenarios and randomized traffic.
module tb_red_pitaya_ams_mon;

  localparam int N_CH    = 16;
  localparam int DW      = 12;
  localparam int AVG_LOG = 4;
  localparam int N_DAC   = 4;
  localparam int DAC_W   = 24;
  localparam int NAVG    = 1 << AVG_LOG;
  localparam int SMAX    = (1 << DW) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   smp_valid_i = 1'b0;
  logic [4:0]             smp_ch_i = '0;
  logic [15:0]            smp_data_i = '0;
  logic [N_DAC*DAC_W-1:0] dac_o;
  logic [N_CH-1:0]        alarm_o;
  logic [31:0]            sys_addr = '0;
  logic [31:0]            sys_wdata = '0;
  logic [3:0]             sys_sel = 4'hF;
  logic                   sys_wen = 1'b0;
  logic                   sys_ren = 1'b0;
  logic [31:0]            sys_rdata;
  logic                   sys_err;
  logic                   sys_ack;

  always #5 clk = ~clk;

  red_pitaya_ams_mon #(
    .N_CH(N_CH), .DW(DW), .AVG_LOG(AVG_LOG),
    .N_DAC(N_DAC), .DAC_W(DAC_W)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .smp_valid_i(smp_valid_i), .smp_ch_i(smp_ch_i),
    .smp_data_i(smp_data_i),
    .dac_o(dac_o), .alarm_o(alarm_o),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata),
    .sys_sel(sys_sel), .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(sys_rdata), .sys_err(sys_err), .sys_ack(sys_ack)
  );

  typedef struct {
    bit          rd;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void check(string name, logic [127:0] act,
                                logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  int          m_last [N_CH];
  int          m_avg  [N_CH];
  int          m_min  [N_CH];
  int          m_max  [N_CH];
  int          m_hi   [N_CH];
  int          m_lo   [N_CH];
  int          m_win  [N_CH][$];
  bit          m_alarm[N_CH];
  int unsigned m_dac  [N_DAC];
  bit          m_frz;

  function automatic void model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_last[i] = 0; m_avg[i] = 0;
      m_min[i] = SMAX; m_max[i] = 0;
      m_hi[i] = SMAX; m_lo[i] = 0;
      m_win[i].delete();
      m_alarm[i] = 0;
    end
    for (int k = 0; k < N_DAC; k++) m_dac[k] = 0;
    m_frz = 0;
  endfunction

  function automatic logic [31:0] model_read(logic [31:0] addr);
    logic [19:0] a;
    int          c;
    logic [31:0] r;
    a = addr[19:0];
    c = int'(a[7:2]);
    r = '0;
    if (a[1:0] != 2'b00) return '0;
    case (a[19:8])
      12'h000: if (c < N_CH) r = m_last[c];
      12'h001: if (c < N_CH) r = m_avg[c];
      12'h002: if (c < N_CH) r = (m_max[c] << 16) | m_min[c];
      12'h003: if (c < N_DAC) r = m_dac[c];
      12'h004: begin
        if (a[7:0] == 8'h00) r = {30'd0, m_frz, 1'b0};
        else if (a[7:0] == 8'h04)
          for (int i = 0; i < N_CH; i++) r[i] = m_alarm[i];
      end
      12'h005: if (c < N_CH) r = (m_hi[c] << 16) | m_lo[c];
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic void model_step(bit wen, logic [31:0] addr,
                                     logic [31:0] wd, bit sv, int ch,
                                     logic [15:0] data);
    logic [19:0] a;
    int          c;
    int          s;
    int          sum;
    a = addr[19:0];
    c = int'(a[7:2]);
    if (wen && a == 20'h00400 && wd[0])
      for (int i = 0; i < N_CH; i++) begin
        m_min[i] = SMAX; m_max[i] = 0;
      end
    if (wen && a == 20'h00404)
      for (int i = 0; i < N_CH; i++) if (wd[i]) m_alarm[i] = 0;
    if (sv && ch < N_CH && !m_frz) begin
      s = int'(data >> (16 - DW));
      m_last[ch] = s;
      if (s < m_min[ch]) m_min[ch] = s;
      if (s > m_max[ch]) m_max[ch] = s;
      m_win[ch].push_back(s);
      if (m_win[ch].size() == NAVG) begin
        sum = 0;
        foreach (m_win[ch][j]) sum += m_win[ch][j];
        m_avg[ch] = sum / NAVG;
        m_win[ch].delete();
        if (m_avg[ch] > m_hi[ch] || m_avg[ch] < m_lo[ch])
          m_alarm[ch] = 1;
      end
    end
    if (wen && a[1:0] == 2'b00) begin
      if (a == 20'h00400) m_frz = wd[1];
      if (a[19:8] == 12'h003 && c < N_DAC)
        m_dac[c] = wd & ((32'd1 << DAC_W) - 1);
      if (a[19:8] == 12'h005 && c < N_CH) begin
        m_hi[c] = int'(wd[16 +: DW]);
        m_lo[c] = int'(wd[0 +: DW]);
      end
    end
  endfunction

  function automatic logic [N_CH-1:0] exp_alarm();
    logic [N_CH-1:0] r;
    for (int i = 0; i < N_CH; i++) r[i] = m_alarm[i];
    return r;
  endfunction

  function automatic logic [N_DAC*DAC_W-1:0] exp_dac();
    logic [N_DAC*DAC_W-1:0] r;
    logic [31:0]            v;
    for (int k = 0; k < N_DAC; k++) begin
      v = m_dac[k];
      r[k*DAC_W +: DAC_W] = v[DAC_W-1:0];
    end
    return r;
  endfunction

  task automatic cyc(input bit ren, input bit wen,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input bit sv, input int ch,
                     input logic [15:0] data, input string nm);
    exp_t e;
    @(negedge clk);
    check("alarm_o", alarm_o, exp_alarm());
    check("dac_o", dac_o, exp_dac());
    check("sys_err", sys_err, 1'b0);
    sys_ren = ren; sys_wen = wen;
    sys_addr = addr; sys_wdata = wd;
    smp_valid_i = sv; smp_ch_i = ch[4:0]; smp_data_i = data;
    if (ren || wen) begin
      e.rd = ren;
      e.exp = ren ? model_read(addr) : '0;
      e.name = nm;
      sb.push_back(e);
    end
    model_step(wen, addr, wd, sv, ch, data);
  endtask

  task automatic idle();
    cyc(0, 0, '0, '0, 0, 0, '0, "");
  endtask

  task automatic rd(input logic [31:0] addr, input string nm);
    cyc(1, 0, addr, '0, 0, 0, '0, nm);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    cyc(0, 1, addr, d, 0, 0, '0, "wr");
  endtask

  task automatic smp(input int ch, input logic [15:0] d);
    cyc(0, 0, '0, '0, 1, ch, d, "");
  endtask

  logic req_d;
  always @(posedge clk or posedge rst)
    if (rst) req_d <= 1'b0;
    else     req_d <= sys_wen | sys_ren;

  // monitor: pops the scoreboard on every acknowledge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (sys_ack || req_d))
        check("ack_timing", sys_ack, req_d);
      if (!rst && sys_ack) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL ack_unexpected: got ack expected none");
        end else begin
          e = sb.pop_front();
          if (e.rd) check(e.name, sys_rdata, e.exp);
        end
      end
    end
  end

  initial begin
    int          ch;
    int          op;
    int          pg;
    int          ix;
    bit          sv;
    logic [31:0] ad;
    logic [31:0] wd;
    logic [15:0] dt;

    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    idle();
    rd(32'h200, "rst_minmax0");
    rd(32'h500, "rst_thr0");
    rd(32'h404, "rst_alarm");
    rd(32'h300, "rst_dac0");

    for (int i = 0; i < 16; i++) smp(3, 16'h1230 + 16'(i * 16'h10));
    rd(32'h10C, "avg3");
    rd(32'h00C, "last3");
    rd(32'h20C, "minmax3");

    wr(32'h50C, 32'h0120_0100);
    for (int i = 0; i < 16; i++) smp(3, 16'h1300);
    idle();
    rd(32'h404, "alarm_set3");
    wr(32'h404, 32'h8);
    idle();
    rd(32'h404, "alarm_w1c3");
    for (int i = 0; i < 15; i++) smp(3, 16'h1300);
    cyc(0, 1, 32'h404, 32'h8, 1, 3, 16'h1300, "w1c_race");
    idle();
    rd(32'h404, "alarm_race3");

    wr(32'h400, 32'h2);
    for (int i = 0; i < 20; i++) smp(5, 16'($urandom));
    rd(32'h014, "frz_last5");
    rd(32'h114, "frz_avg5");
    rd(32'h214, "frz_mm5");
    rd(32'h400, "ctrl_frz");
    wr(32'h400, 32'h0);
    for (int i = 0; i < 16; i++) smp(5, 16'h4000 + 16'(i * 16'h30));
    rd(32'h114, "unfrz_avg5");

    cyc(0, 1, 32'h400, 32'h1, 1, 7, 16'h0800, "clr_race");
    rd(32'h21C, "clr_mm7");
    rd(32'h20C, "clr_mm3");
    rd(32'h200, "clr_mm0");
    rd(32'h400, "ctrl_rd0");

    wr(32'h304, 32'hFFFF_FFFF);
    rd(32'h304, "dac1");
    wr(32'h340, 32'h5);
    rd(32'h340, "dac16");
    smp(31, 16'hFFF0);
    smp(16, 16'hFFF0);
    rd(32'h040, "last16");
    rd(32'h401, "unaligned");
    rd(32'h600, "unmapped");

    for (int n = 0; n < 800; n++) begin
      sv = ($urandom_range(0, 9) < 7);
      ch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(16, 31))
                                       : int'($urandom_range(0, 15));
      dt = 16'($urandom);
      op = int'($urandom_range(0, 9));
      pg = int'($urandom_range(0, 5));
      ix = int'($urandom_range(0, 17));
      if (pg == 4) ix = int'($urandom_range(0, 2));
      ad = ($urandom & 32'hFFF0_0000) | 32'(pg << 8) | 32'(ix << 2);
      if (op < 3) begin
        cyc(1, 0, ad, '0, sv, ch, dt, "rnd_read");
      end else if (op == 3) begin
        wd = {4'd0, 12'($urandom_range(12'h600, 12'hFFF)),
              4'd0, 12'($urandom_range(0, 12'h300))};
        ad = 32'h500 | 32'($urandom_range(0, 15) << 2);
        cyc(0, 1, ad, wd, sv, ch, dt, "rnd_thr");
      end else if (op == 4) begin
        ad = 32'h300 | 32'($urandom_range(0, 5) << 2);
        cyc(0, 1, ad, $urandom, sv, ch, dt, "rnd_dac");
      end else if (op == 5) begin
        wd = 32'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) wd[1] = 1'b1;
        cyc(0, 1, 32'h400, wd, sv, ch, dt, "rnd_ctrl");
      end else if (op == 6) begin
        cyc(0, 1, 32'h404, $urandom, sv, ch, dt, "rnd_w1c");
      end else begin
        cyc(0, 0, '0, '0, sv, ch, dt, "");
      end
    end

    for (int c = 0; c <= N_CH; c++) begin
      rd(32'(c << 2), $sformatf("last%0d", c));
      rd(32'h100 | 32'(c << 2), $sformatf("avg%0d", c));
      rd(32'h200 | 32'(c << 2), $sformatf("minmax%0d", c));
      rd(32'h500 | 32'(c << 2), $sformatf("thr%0d", c));
    end
    for (int k = 0; k <= N_DAC; k++)
      rd(32'h300 | 32'(k << 2), $sformatf("dac%0d", k));
    rd(32'h400, "ctrl_end");
    rd(32'h404, "alarm_end");
    repeat (3) idle();
    check("sb_drain", 128'(sb.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
